// File: rtl/rfPhoenixPkg.sv
// rtl/rfPhoenixPkg.sv - shared vector types and write-back entry layout
package rfPhoenixPkg;

    localparam int NLANES = 16;

    typedef logic [3:0]            tid_t;
    typedef logic [5:0]            regspec_t;
    typedef logic [NLANES*32-1:0]  vector_value_t;

    typedef struct packed {
        tid_t          tid;
        regspec_t      rd;
        logic [63:0]   mask;
        vector_value_t res;
    } wb_entry_t;

    // Destination match used by the RAW hazard lookup.
    function automatic logic dest_match(input tid_t et, input regspec_t er,
                                        input tid_t t, input regspec_t r);
        return (et == t) && (er == r);
    endfunction

endpackage

// File: rtl/rfPhoenix_rr_arb2.sv
// rtl/rfPhoenix_rr_arb2.sv - two-request round-robin arbiter with last-grant state
module rfPhoenix_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // last_q = 1 means port 1 was granted most recently.
    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt_o[1]) begin
            last_d = 1'b1;
        end else if (gnt_o[0]) begin
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rfphoenix_vec_wb_queue.sv
// rtl/rfphoenix_vec_wb_queue.sv - two-port vector write-back queue feeding the register file
module rfphoenix_vec_wb_queue
    import rfPhoenixPkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s0_v,
    output logic          s0_rdy,
    input  tid_t          s0_tid,
    input  regspec_t      s0_rd,
    input  logic [63:0]   s0_mask,
    input  vector_value_t s0_res,
    input  logic          s1_v,
    output logic          s1_rdy,
    input  tid_t          s1_tid,
    input  regspec_t      s1_rd,
    input  logic [63:0]   s1_mask,
    input  vector_value_t s1_res,
    input  logic          hold,
    input  tid_t          q_tid,
    input  regspec_t      q_rd,
    output logic          q_hit,
    output logic          wr,
    output tid_t          wthread,
    output regspec_t      wa,
    output logic [63:0]   wmask,
    output vector_value_t wdat,
    output logic [CNTW-1:0] count,
    output logic          full
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

    logic [PTRW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    wb_entry_t       mem_q [DEPTH];
    wb_entry_t       in_ent;
    wb_entry_t       head;

    logic          wr_q, wr_d;
    tid_t          wthread_q, wthread_d;
    regspec_t      wa_q, wa_d;
    logic [63:0]   wmask_q, wmask_d;
    vector_value_t wdat_q, wdat_d;

    logic       space, push, pop;
    logic [1:0] req, gnt;

    // Occupancy is judged before any same-cycle pop, so a full queue never accepts.
    assign space = (count_q < DEPTH_C);
    assign req   = {s1_v & space, s0_v & space};

    rfPhoenix_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign s0_rdy = gnt[0];
    assign s1_rdy = gnt[1];

    always_comb begin
        in_ent = '{tid: s0_tid, rd: s0_rd, mask: s0_mask, res: s0_res};
        if (gnt[1]) begin
            in_ent = '{tid: s1_tid, rd: s1_rd, mask: s1_mask, res: s1_res};
        end
    end

    // Zero-mask results are acknowledged but never reach the regfile.
    assign push = (|gnt) && (in_ent.mask != 64'd0);
    assign pop  = (count_q != '0) && !hold;
    assign head = mem_q[rp_q];

    always_comb begin
        wp_d    = push ? wp_q + 1'b1 : wp_q;
        rp_d    = pop  ? rp_q + 1'b1 : rp_q;
        count_d = count_q + CNTW'(push) - CNTW'(pop);
        vld_d   = vld_q;
        if (pop) begin
            vld_d[rp_q] = 1'b0;
        end
        if (push) begin
            vld_d[wp_q] = 1'b1;
        end
    end

    always_comb begin
        wr_d      = pop;
        wthread_d = wthread_q;
        wa_d      = wa_q;
        wmask_d   = wmask_q;
        wdat_d    = wdat_q;
        if (pop) begin
            wthread_d = head.tid;
            wa_d      = head.rd;
            wmask_d   = head.mask;
            wdat_d    = head.res;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= in_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q      <= '0;
            rp_q      <= '0;
            count_q   <= '0;
            vld_q     <= '0;
            wr_q      <= 1'b0;
            wthread_q <= '0;
            wa_q      <= '0;
            wmask_q   <= '0;
            wdat_q    <= '0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            count_q   <= count_d;
            vld_q     <= vld_d;
            wr_q      <= wr_d;
            wthread_q <= wthread_d;
            wa_q      <= wa_d;
            wmask_q   <= wmask_d;
            wdat_q    <= wdat_d;
        end
    end

    // The in-flight output register still counts as pending while wr is high.
    always_comb begin
        q_hit = wr_q && dest_match(wthread_q, wa_q, q_tid, q_rd);
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && dest_match(mem_q[i].tid, mem_q[i].rd, q_tid, q_rd)) begin
                q_hit = 1'b1;
            end
        end
    end

    assign wr      = wr_q;
    assign wthread = wthread_q;
    assign wa      = wa_q;
    assign wmask   = wmask_q;
    assign wdat    = wdat_q;
    assign count   = count_q;
    assign full    = (count_q == DEPTH_C);

endmodule
